// File: rtl/rom_seq_reader.sv
// Sequential reader that scans an asynchronous ROM once per start request and hands each word downstream over a valid/ready handshake.
// Optional build macro ROM_READER_CHKSUM_EN adds the chksum output (running XOR of accepted words).
module rom_seq_reader #(
  parameter int ADDR_W = 2,
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] rom_data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  input  logic              data_ready,
  output logic              busy,
  output logic              done
`ifdef ROM_READER_CHKSUM_EN
  ,
  output logic [DATA_W-1:0] chksum
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam logic [ADDR_W-1:0] CNT_MAX = '1;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] data_q, data_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FETCH;
          cnt_d   = '0;
        end
      end
      S_FETCH: begin
        data_d  = rom_data_in;
        state_d = S_HOLD;
      end
      S_HOLD: begin
        // Last word accepted goes to DONE without incrementing, so the counter never wraps mid-scan.
        if (data_ready) begin
          if (cnt_q == CNT_MAX) begin
            cnt_d   = '0;
            state_d = S_DONE;
          end else begin
            cnt_d   = cnt_q + ADDR_W'(1);
            state_d = S_FETCH;
          end
        end
      end
      S_DONE: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign address    = (state_q == S_IDLE) ? '0 : cnt_q;
  assign data_out   = data_q;
  assign data_valid = (state_q == S_HOLD);
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);

`ifdef ROM_READER_CHKSUM_EN
  logic [DATA_W-1:0] chk_q, chk_d;
  logic              start_acc, word_acc;

  assign start_acc = (state_q == S_IDLE) && start;
  assign word_acc  = (state_q == S_HOLD) && data_ready;

  always_comb begin
    chk_d = chk_q;
    if (start_acc) begin
      chk_d = '0;
    end else if (word_acc) begin
      chk_d = chk_q ^ data_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chk_q <= '0;
    end else begin
      chk_q <= chk_d;
    end
  end

  assign chksum = chk_q;
`endif

endmodule

// File: tb/tb_rom_seq_reader.sv
// Directed self-checking bench for rom_seq_reader with a 4-word ROM {A,5,3,F}.
module tb_rom_seq_reader;

  logic       clk;
  logic       rst;
  logic       start;
  logic [1:0] address;
  logic [3:0] rom_data_in;
  logic [3:0] data_out;
  logic       data_valid;
  logic       data_ready;
  logic       busy;
  logic       done;
`ifdef ROM_READER_CHKSUM_EN
  logic [3:0] chksum;
`endif

  logic [3:0] rom [4];
  logic [3:0] exp_w [4];
  logic [3:0] acc_q [$];
  int         done_cnt;
  int         n_cmp;
  int         n_err;

  rom_seq_reader #(.ADDR_W(2), .DATA_W(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .address     (address),
    .rom_data_in (rom_data_in),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .data_ready  (data_ready),
    .busy        (busy),
    .done        (done)
`ifdef ROM_READER_CHKSUM_EN
    ,
    .chksum      (chksum)
`endif
  );

  assign rom_data_in = rom[address];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Accepted words and done pulses are logged mid-cycle, where inputs equal their value at the next edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (data_valid && data_ready) acc_q.push_back(data_out);
      if (done) done_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    acc_q.delete();
    done_cnt = 0;
  endtask

  task automatic wait_valid(input int budget);
    int n = 0;
    while (!data_valid && n < budget) begin
      step();
      n++;
    end
    if (!data_valid) check("valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!done && n < budget) begin
      step();
      n++;
    end
    if (!done) check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_seq(input string tag, input int n);
    check({tag, "_count"}, acc_q.size(), n);
    for (int i = 0; i < n; i++) begin
      check({tag, "_word"}, (i < acc_q.size()) ? {28'd0, acc_q[i]} : 32'hDEAD, {28'd0, exp_w[i % 4]});
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    done_cnt = 0;
    rom[0] = 4'hA; rom[1] = 4'h5; rom[2] = 4'h3; rom[3] = 4'hF;
    exp_w[0] = 4'hA; exp_w[1] = 4'h5; exp_w[2] = 4'h3; exp_w[3] = 4'hF;
    rst = 1'b1;
    start = 1'b0;
    data_ready = 1'b0;

    // Reset state
    #3;
    check("rst_state", {busy, done, data_valid}, 3'b000);
    check("rst_addr", address, 2'd0);
    check("rst_data", data_out, 4'h0);
`ifdef ROM_READER_CHKSUM_EN
    check("rst_chksum", chksum, 4'h0);
`endif
    step();
    rst = 1'b0;
    step();

    // Ready tied high, single start pulse, exact latency
    clear_log();
    start = 1'b1;
    data_ready = 1'b1;
    step();                       // edge N samples start
    start = 1'b0;
    check("lat_fetch_busy", busy, 1'b1);
    check("lat_fetch_valid", data_valid, 1'b0);
    step();                       // N+1
    check("lat_first_valid", data_valid, 1'b1);
    check("lat_first_data", data_out, 4'hA);
    check("lat_first_addr", address, 2'd0);
    repeat (6) @(posedge clk);    // N+7
    #1;
    check("lat_last_data", data_out, 4'hF);
    check("lat_last_addr", address, 2'd3);
    check("lat_no_early_done", done, 1'b0);
    step();                       // N+8
    check("lat_done", done, 1'b1);
    step();                       // N+9
    check("lat_idle", {busy, done}, 2'b00);
    step();
    check_seq("fast", 4);
    check("fast_done_cnt", done_cnt, 1);
`ifdef ROM_READER_CHKSUM_EN
    check("fast_chksum", chksum, 4'h3);
`endif

    // Stalled acceptance: 3 unready cycles per word
    clear_log();
    data_ready = 1'b0;
    pulse_start();
    for (int w = 0; w < 4; w++) begin
      wait_valid(10);
      repeat (3) begin
        check("stall_data", data_out, exp_w[w]);
        check("stall_addr", address, w[1:0]);
        check("stall_valid", data_valid, 1'b1);
        step();
      end
      data_ready = 1'b1;
      step();
      data_ready = 1'b0;
      check("stall_valid_drop", data_valid, 1'b0);
    end
    step();
    step();
    check_seq("stall", 4);
    check("stall_done_cnt", done_cnt, 1);

    // Start pulsed while busy on word 2 is ignored
    clear_log();
    data_ready = 1'b1;
    pulse_start();
    wait_valid(10);
    while (acc_q.size() < 1 && busy) step();
    pulse_start();
    wait_done(20);
    repeat (6) step();
    check("ign_busy", busy, 1'b0);
    check_seq("ign", 4);
    check("ign_done_cnt", done_cnt, 1);

    // Reset in HOLD at address 2
    clear_log();
    data_ready = 1'b0;
    pulse_start();
    for (int w = 0; w < 2; w++) begin
      wait_valid(10);
      data_ready = 1'b1;
      step();
      data_ready = 1'b0;
    end
    wait_valid(10);
    check("rstmid_addr2", address, 2'd2);
    #2;
    rst = 1'b1;
    #1;
    check("rstmid_ctrl", {busy, done, data_valid}, 3'b000);
    check("rstmid_addr", address, 2'd0);
    check("rstmid_data", data_out, 4'h0);
`ifdef ROM_READER_CHKSUM_EN
    check("rstmid_chksum", chksum, 4'h0);
`endif
    step();
    rst = 1'b0;
    check("rstmid_no_done", done_cnt, 0);
    clear_log();
    data_ready = 1'b1;
    pulse_start();
    wait_done(20);
    step();
    check_seq("rstmid_restart", 4);

    // Start held high: back-to-back scans with one IDLE cycle
    clear_log();
    data_ready = 1'b1;
    start = 1'b1;
    wait_done(20);
    step();
    check("b2b_idle_gap", busy, 1'b0);
    step();
    check("b2b_restart", busy, 1'b1);
    wait_done(20);
    start = 1'b0;
    step();
    step();
    check("b2b_stop", busy, 1'b0);
    check_seq("b2b", 8);
    check("b2b_done_cnt", done_cnt, 2);
`ifdef ROM_READER_CHKSUM_EN
    check("b2b_chksum", chksum, 4'h3);
`endif

    // Ready high throughout IDLE has no effect
    clear_log();
    data_ready = 1'b1;
    repeat (4) step();
    check("idle_ready_no_acc", acc_q.size(), 0);
    check("idle_ready_busy", busy, 1'b0);
    pulse_start();
    check("idle_ready_fetch_valid", data_valid, 1'b0);
    wait_done(20);
    step();
    check_seq("idle_ready", 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/rom_seq_reader.md
ROM_SEQ_READER -- requirements
Module: rom_seq_reader

Interface
REQ-001 Parameter ADDR_W, default 2: address width; ROM depth is 2**ADDR_W words.
REQ-002 Parameter DATA_W, default 4: ROM word width.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 start  input  1  request one full ROM scan; sampled only in IDLE.
REQ-006 address  output  ADDR_W  address driven to the asynchronous ROM.
REQ-007 rom_data_in  input  DATA_W  combinational ROM read data for the current address.
REQ-008 data_out  output  DATA_W  registered ROM word presented downstream.
REQ-009 data_valid  output  1  data_out holds a word not yet accepted.
REQ-010 data_ready  input  1  downstream accepts data_out when high with data_valid high.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 done  output  1  one-cycle pulse after the last word is accepted.
REQ-013 chksum  output  DATA_W  running XOR of accepted words; present only with ROM_READER_CHKSUM_EN.

Function
REQ-014 The FSM SHALL have states IDLE, FETCH, HOLD and DONE, encoded in registers.
REQ-015 IDLE: address=0, data_valid=0, busy=0; start=1 at an edge -> FETCH; otherwise stay.
REQ-016 FETCH: address = internal counter; next edge latches rom_data_in into data_out, sets data_valid -> HOLD.
REQ-017 HOLD: data_valid=1; data_out and address stable until an edge with data_ready=1.
REQ-018 HOLD with data_ready=1: counter < 2**ADDR_W-1 -> counter+1, FETCH; counter == max -> DONE.
REQ-019 data_valid SHALL drop at the same edge that a word is accepted; no word is repeated or skipped.
REQ-020 data_ready asserted outside HOLD SHALL have no effect.
REQ-021 DONE: done=1 for exactly one cycle; counter cleared to 0; next edge -> IDLE.
REQ-022 Counter SHALL NOT wrap within a scan; it returns to 0 only via DONE or reset.
REQ-023 start while busy=1 SHALL be ignored and not queued.
REQ-024 start held high continuously SHALL begin a new scan on the edge after DONE returns to IDLE.
REQ-025 Latency: start sampled at edge N -> data_valid high after edge N+1; minimum 2 cycles per word.
REQ-026 With data_ready tied high, a 4-word scan SHALL assert done in the cycle after edge N+8 and be back in IDLE after edge N+9.

Reset
REQ-027 rst=1 SHALL immediately force IDLE, counter=0, address=0, data_out=0, data_valid=0, busy=0, done=0, chksum=0.
REQ-028 Reset mid-scan SHALL abandon the scan with no done pulse; next scan restarts at address 0.

Configuration
REQ-029 Macro ROM_READER_CHKSUM_EN defined: chksum port exists, cleared on start acceptance in IDLE, XORed with data_out at each accepted word, held from DONE until next start.
REQ-030 Macro undefined: chksum port and its logic SHALL be absent; all other behaviour identical.

Verification
REQ-031 ROM {0:A,1:5,2:3,3:F}, data_ready=1, start pulse -> data_out A,5,3,F on successive valid cycles, one done pulse, chksum=3 (macro on).
REQ-032 Same ROM, data_ready low 3 cycles per word -> data_out/address stable while valid and unaccepted, identical sequence, no duplicates.
REQ-033 start pulsed during word 2 -> ignored; exactly 4 words and one done.
REQ-034 rst asserted in HOLD at address 2 -> outputs zero immediately, no done; new start yields A first.
REQ-035 start held high -> two back-to-back scans A,5,3,F,A,5,3,F with one IDLE cycle between.
REQ-036 data_ready high throughout IDLE -> no effect; first acceptance occurs only after data_valid rises.
